// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: memory op, load type, store masks,
// FSM state codes and the access-size helper used for alignment and lane replication.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'b00,
    MEM_OP_LOAD  = 2'b01,
    MEM_OP_STORE = 2'b10
  } mem_op_e;

  typedef enum logic [2:0] {
    MEM_RD_NONE = 3'b000,
    MEM_RD_BYTE = 3'b001,
    MEM_RD_HALF = 3'b010,
    MEM_RD_WORD = 3'b011,
    MEM_RD_B_U  = 3'b100,
    MEM_RD_H_U  = 3'b101
  } mem_rd_e;

  localparam logic [3:0] MEM_WR_NONE = 4'b0000;
  localparam logic [3:0] MEM_WR_BYTE = 4'b0001;
  localparam logic [3:0] MEM_WR_HALF = 4'b0011;
  localparam logic [3:0] MEM_WR_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } acc_size_e;

  // Stores take their size from the byte mask, loads from the load type.
  function automatic acc_size_e acc_size(input logic [1:0] op, input logic [2:0] rd,
                                         input logic [3:0] mask);
    acc_size_e sz;
    sz = SZ_BYTE;
    if (op == MEM_OP_STORE) begin
      case (mask)
        MEM_WR_HALF: sz = SZ_HALF;
        MEM_WR_WORD: sz = SZ_WORD;
        default:     sz = SZ_BYTE;
      endcase
    end else begin
      case (rd)
        MEM_RD_HALF, MEM_RD_H_U: sz = SZ_HALF;
        MEM_RD_WORD:             sz = SZ_WORD;
        default:                 sz = SZ_BYTE;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational load lane select and sign/zero extension of a 32-bit bus word.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  rd_type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (rd_type_i)
      MEM_RD_BYTE: data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_RD_B_U:  data_o = {24'h0, byte_sel};
      MEM_RD_HALF: data_o = {{16{half_sel[15]}}, half_sel};
      MEM_RD_H_U:  data_o = {16'h0, half_sel};
      MEM_RD_WORD: data_o = word_i;
      default:     data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time on a word-aligned data bus with ack timeout.
// Optional macro LSU_MISALIGN_CHECK_EN: flag misaligned accesses instead of aligning them down.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  mem_read_type,
  input  logic [3:0]  mem_write_mask,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        misaligned,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(BUS_TIMEOUT);

  lsu_state_e       state_q;
  logic [1:0]       op_q;
  logic [2:0]       rd_q;
  logic [1:0]       lane_q;
  logic [CNT_W-1:0] wait_cnt_q, cnt_d;
  logic             busy_q, done_q, mis_q, err_q;
  logic [31:0]      rdata_q;
  logic             dreq_q, dwe_q;
  logic [31:0]      daddr_q, dwdata_q;
  logic [3:0]       dwstrb_q;

  acc_size_e   size_d;
  logic        is_mem, is_store, mis_d, timeout_hit;
  logic [31:0] addr_d, wdata_d, ext_data;
  logic [3:0]  wstrb_d;

  assign size_d   = acc_size(mem_op, mem_read_type, mem_write_mask);
  assign is_store = (mem_op == MEM_OP_STORE);
  assign is_mem   = (mem_op == MEM_OP_LOAD) || is_store;

`ifdef LSU_MISALIGN_CHECK_EN
  assign addr_d = addr;
  assign mis_d  = is_mem && (((size_d == SZ_HALF) && addr[0]) ||
                             ((size_d == SZ_WORD) && (addr[1:0] != 2'b00)));
`else
  always_comb begin
    case (size_d)
      SZ_HALF: addr_d = {addr[31:1], 1'b0};
      SZ_WORD: addr_d = {addr[31:2], 2'b00};
      default: addr_d = addr;
    endcase
  end
  assign mis_d = 1'b0;
`endif

  assign wstrb_d = mem_write_mask << addr_d[1:0];

  always_comb begin
    case (size_d)
      SZ_BYTE: wdata_d = {4{wdata[7:0]}};
      SZ_HALF: wdata_d = {2{wdata[15:0]}};
      default: wdata_d = wdata;
    endcase
  end

  assign cnt_d       = wait_cnt_q + CNT_W'(1);
  // An ack in the same cycle still wins; this only matters when ack is absent.
  assign timeout_hit = (BUS_TIMEOUT != 0) && (cnt_d == TMO);

  load_extend u_load_extend (
    .word_i    (dbus_rdata),
    .lane_i    (lane_q),
    .rd_type_i (rd_q),
    .data_o    (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= 2'b00;
      rd_q       <= 3'b000;
      lane_q     <= 2'b00;
      wait_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
      dreq_q     <= 1'b0;
      dwe_q      <= 1'b0;
      daddr_q    <= 32'h0;
      dwstrb_q   <= 4'h0;
      dwdata_q   <= 32'h0;
    end else begin
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (start) begin
            op_q       <= mem_op;
            rd_q       <= mem_read_type;
            lane_q     <= addr_d[1:0];
            wait_cnt_q <= '0;
            busy_q     <= 1'b1;
            if (!is_mem || mis_d) begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              mis_q   <= mis_d;
            end else begin
              state_q  <= ST_REQ;
              dreq_q   <= 1'b1;
              dwe_q    <= is_store;
              daddr_q  <= {addr_d[31:2], 2'b00};
              dwstrb_q <= is_store ? wstrb_d : 4'h0;
              dwdata_q <= is_store ? wdata_d : 32'h0;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (dbus_ack || timeout_hit) begin
            state_q  <= ST_RESP;
            done_q   <= 1'b1;
            err_q    <= !dbus_ack;
            rdata_q  <= (dbus_ack && (op_q == MEM_OP_LOAD)) ? ext_data : 32'h0;
            dreq_q   <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= 32'h0;
            dwstrb_q <= 4'h0;
            dwdata_q <= 32'h0;
          end else begin
            wait_cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          dreq_q   <= 1'b0;
          dwe_q    <= 1'b0;
          daddr_q  <= 32'h0;
          dwstrb_q <= 4'h0;
          dwdata_q <= 32'h0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata_out  = rdata_q;
  assign misaligned = mis_q;
  assign bus_err    = err_q;
  assign dbus_req   = dreq_q;
  assign dbus_we    = dwe_q;
  assign dbus_addr  = daddr_q;
  assign dbus_wstrb = dwstrb_q;
  assign dbus_wdata = dwdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with BUS_TIMEOUT=4; expectations follow
// LSU_MISALIGN_CHECK_EN when it is defined for the build.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mem_op = 2'b00;
  logic [2:0]  mem_read_type = 3'b000;
  logic [3:0]  mem_write_mask = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, misaligned, bus_err;
  logic [31:0] rdata_out;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_ack = 1'b0;
  logic [31:0] dbus_rdata = 32'h0;

  load_store_unit #(.BUS_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mem_op         (mem_op),
    .mem_read_type  (mem_read_type),
    .mem_write_mask (mem_write_mask),
    .addr           (addr),
    .wdata          (wdata),
    .busy           (busy),
    .done           (done),
    .rdata_out      (rdata_out),
    .misaligned     (misaligned),
    .bus_err        (bus_err),
    .dbus_req       (dbus_req),
    .dbus_we        (dbus_we),
    .dbus_addr      (dbus_addr),
    .dbus_wstrb     (dbus_wstrb),
    .dbus_wdata     (dbus_wdata),
    .dbus_ack       (dbus_ack),
    .dbus_rdata     (dbus_rdata)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_we;
  int          req_cyc;
  logic        stable;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one access, ack it ack_dly REQ cycles in (-1 = never), check the completion.
  task automatic access(input string tag, input logic [1:0] op, input logic [2:0] rt,
                        input logic [3:0] mk, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] bus_rd, input int ack_dly, input int exp_n,
                        input logic [31:0] exp_rd, input logic exp_mis, input logic exp_err);
    int n;
    n = 0;
    @(negedge clk);
    start = 1'b1; mem_op = op; mem_read_type = rt; mem_write_mask = mk; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    req_cyc = 0; stable = 1'b1;
    cap_addr = dbus_addr; cap_wdata = dbus_wdata; cap_wstrb = dbus_wstrb; cap_we = dbus_we;
    while (!done && n < 20) begin
      if (dbus_req) begin
        req_cyc++;
        if (dbus_addr !== cap_addr || dbus_wdata !== cap_wdata ||
            dbus_wstrb !== cap_wstrb || dbus_we !== cap_we) stable = 1'b0;
      end
      if (dbus_req && n == ack_dly) begin
        dbus_ack = 1'b1; dbus_rdata = bus_rd;
      end
      @(negedge clk);
      dbus_ack = 1'b0; dbus_rdata = 32'h0;
      n++;
    end
    check_val({tag, ".done"}, 32'(done), 32'd1);
    check_val({tag, ".latency"}, 32'(n), 32'(exp_n));
    check_val({tag, ".rdata"}, rdata_out, exp_rd);
    check_val({tag, ".misaligned"}, 32'(misaligned), 32'(exp_mis));
    check_val({tag, ".bus_err"}, 32'(bus_err), 32'(exp_err));
    check_val({tag, ".stable"}, 32'(stable), 32'd1);
    $display("%s: op=%0d addr=%h rdata_out=%h mis=%0b err=%0b req_cycles=%0d",
             tag, op, a, rdata_out, misaligned, bus_err, req_cyc);
    @(negedge clk);
    check_val({tag, ".pulse_end"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check_val("rst.busy", 32'(busy), 32'd0);
    check_val("rst.done", 32'(done), 32'd0);
    check_val("rst.dbus_req", 32'(dbus_req), 32'd0);
    check_val("rst.rdata", rdata_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    access("lb", MEM_OP_LOAD, MEM_RD_BYTE, MEM_WR_NONE, 32'h103, 32'h0, 32'h80FF_1234,
           2, 3, 32'hFFFF_FF80, 1'b0, 1'b0);
    check_val("lb.dbus_addr", cap_addr, 32'h100);
    check_val("lb.we_wstrb", {27'h0, cap_we, cap_wstrb}, 32'h0);
    check_val("lb.req_cycles", 32'(req_cyc), 32'd3);

    access("sh", MEM_OP_STORE, MEM_RD_NONE, MEM_WR_HALF, 32'h202, 32'h0000_ABCD, 32'h5555_5555,
           0, 1, 32'h0, 1'b0, 1'b0);
    check_val("sh.dbus_addr", cap_addr, 32'h200);
    check_val("sh.wstrb", 32'(cap_wstrb), 32'hC);
    check_val("sh.wdata", cap_wdata, 32'hABCD_ABCD);
    check_val("sh.we", 32'(cap_we), 32'd1);

    access("sb", MEM_OP_STORE, MEM_RD_NONE, MEM_WR_BYTE, 32'h301, 32'h1234_5678, 32'h0,
           1, 2, 32'h0, 1'b0, 1'b0);
    check_val("sb.wstrb", 32'(cap_wstrb), 32'h2);
    check_val("sb.wdata", cap_wdata, 32'h7878_7878);
    check_val("sb.dbus_addr", cap_addr, 32'h300);

    access("sw", MEM_OP_STORE, MEM_RD_NONE, MEM_WR_WORD, 32'h304, 32'h1234_5678, 32'h0,
           0, 1, 32'h0, 1'b0, 1'b0);
    check_val("sw.wstrb", 32'(cap_wstrb), 32'hF);
    check_val("sw.wdata", cap_wdata, 32'h1234_5678);

    access("lhu", MEM_OP_LOAD, MEM_RD_H_U, MEM_WR_NONE, 32'h2, 32'h0, 32'h8001_0000,
           0, 1, 32'h0000_8001, 1'b0, 1'b0);
    access("lh", MEM_OP_LOAD, MEM_RD_HALF, MEM_WR_NONE, 32'h2, 32'h0, 32'h8001_0000,
           0, 1, 32'hFFFF_8001, 1'b0, 1'b0);
    access("lbu", MEM_OP_LOAD, MEM_RD_B_U, MEM_WR_NONE, 32'h1, 32'h0, 32'h0000_AB00,
           1, 2, 32'h0000_00AB, 1'b0, 1'b0);
    access("lw", MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h8, 32'h0, 32'h1122_3344,
           0, 1, 32'h1122_3344, 1'b0, 1'b0);

`ifdef LSU_MISALIGN_CHECK_EN
    access("lw_mis", MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h101, 32'h0, 32'hDEAD_BEEF,
           0, 0, 32'h0, 1'b1, 1'b0);
    check_val("lw_mis.req_cycles", 32'(req_cyc), 32'd0);
`else
    access("lw_mis", MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h101, 32'h0, 32'hDEAD_BEEF,
           0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check_val("lw_mis.dbus_addr", cap_addr, 32'h100);
`endif

    access("none", MEM_OP_NONE, MEM_RD_NONE, MEM_WR_NONE, 32'h10, 32'h0, 32'h0,
           0, 0, 32'h0, 1'b0, 1'b0);
    check_val("none.req_cycles", 32'(req_cyc), 32'd0);

    access("timeout", MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h40, 32'h0, 32'h0,
           -1, 4, 32'h0, 1'b0, 1'b1);
    check_val("timeout.req_cycles", 32'(req_cyc), 32'd4);

    access("ack_at_limit", MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h44, 32'h0, 32'hCAFE_BABE,
           3, 4, 32'hCAFE_BABE, 1'b0, 1'b0);

    // Stray ack while idle must not produce a completion.
    @(negedge clk);
    dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    check_val("stray_ack.done_busy", 32'({done, busy}), 32'd0);
    $display("stray_ack: done=%0b busy=%0b", done, busy);

    // New start accepted in the cycle done is high.
    @(negedge clk);
    start = 1'b1; mem_op = MEM_OP_NONE; mem_read_type = MEM_RD_NONE; mem_write_mask = MEM_WR_NONE;
    @(negedge clk);
    check_val("b2b.first_done", 32'(done), 32'd1);
    mem_op = MEM_OP_LOAD; mem_read_type = MEM_RD_H_U; addr = 32'h2;
    @(negedge clk);
    start = 1'b0;
    check_val("b2b.dbus_req", 32'(dbus_req), 32'd1);
    dbus_ack = 1'b1; dbus_rdata = 32'h8001_0000;
    @(negedge clk);
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    check_val("b2b.second_done", 32'(done), 32'd1);
    check_val("b2b.rdata", rdata_out, 32'h0000_8001);
    $display("b2b: rdata_out=%h", rdata_out);

    // Reset in the middle of a bus request.
    @(negedge clk);
    start = 1'b1; mem_op = MEM_OP_LOAD; mem_read_type = MEM_RD_WORD; addr = 32'h80;
    @(negedge clk);
    start = 1'b0;
    check_val("rst_mid.req_before", 32'(dbus_req), 32'd1);
    rst = 1'b1;
    #1;
    check_val("rst_mid.dbus_req", 32'(dbus_req), 32'd0);
    check_val("rst_mid.busy", 32'(busy), 32'd0);
    $display("rst_mid: dbus_req=%0b busy=%0b", dbus_req, busy);
    @(negedge clk);
    rst = 1'b0;
    access("lhu_after_rst", MEM_OP_LOAD, MEM_RD_H_U, MEM_WR_NONE, 32'h0, 32'h0, 32'h0000_8001,
           0, 1, 32'h0000_8001, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 255: maximum cycles spent waiting for dbus_ack; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: accept an access when idle.
REQ-005 SHALL have ports mem_op (input, 2) and mem_read_type (input, 3): access type and load type; encodings per REQ-034.
REQ-006 SHALL have port mem_write_mask, input, 4: unshifted store byte mask: NONE 0000, BYTE 0001, HALF 0011, WORD 1111.
REQ-007 SHALL have ports addr (input, 32, byte address from ALU) and wdata (input, 32, store data from rs2).
REQ-008 SHALL have port busy, output, 1: an access is in progress.
REQ-009 SHALL have ports done (output, 1, one-cycle completion pulse) and rdata_out (output, 32, extended load result).
REQ-010 SHALL have ports misaligned and bus_err, both output, 1, each valid while done is high.
REQ-011 SHALL have dbus outputs: dbus_req (1), dbus_we (1), dbus_addr (32, word-aligned), dbus_wstrb (4), dbus_wdata (32).
REQ-012 SHALL have dbus inputs: dbus_ack (1) and dbus_rdata (32, word read data, valid with ack).

Function
REQ-013 SHALL implement FSM IDLE -> REQ -> RESP -> IDLE.
REQ-014 In IDLE, start=1 SHALL latch all inputs and transition out of IDLE; start while not IDLE SHALL be ignored.
REQ-015 On start with mem_op=NONE, the unit SHALL go directly to RESP (done next cycle, no bus activity).
REQ-016 On start with a misaligned access, the unit SHALL go to RESP with misaligned=1 and no bus activity.
REQ-017 Misaligned SHALL mean: half with addr[0]=1, or word with addr[1:0]!=00.
REQ-018 In REQ, dbus_req SHALL be 1, with dbus_addr = {addr[31:2],2'b00} and dbus_we=1 for stores only.
REQ-019 For stores, dbus_wstrb SHALL be mem_write_mask<<addr[1:0] and dbus_wdata SHALL be wdata replicated into lanes (byte x4, half x2, word as-is).
REQ-020 For loads, dbus_wstrb SHALL be 0000.
REQ-021 All dbus outputs SHALL be held stable from request until ack.
REQ-022 dbus_ack=1 in REQ SHALL capture dbus_rdata and move to RESP; ack outside REQ SHALL be ignored.
REQ-023 Response latency: ack in cycle M SHALL give done=1 in cycle M+1; minimum start-to-done is 2 cycles with a same-cycle ack.
REQ-024 In RESP, done SHALL be 1 for exactly one cycle, followed by a return to IDLE; a new start SHALL be accepted in the same cycle done is high.
REQ-025 Load extraction SHALL select lane addr[1:0]: BYTE sign-extends bits[7:0], B_U zero-extends, HALF sign-extends, H_U zero-extends, WORD passes 32 bits through.
REQ-026 rdata_out SHALL be 0 for stores, mem_op=NONE, misaligned and bus_err completions.
REQ-027 A wait counter SHALL count REQ cycles; reaching BUS_TIMEOUT without ack SHALL drop dbus_req and go to RESP with bus_err=1.
REQ-028 An ack arriving in the same cycle the count reaches BUS_TIMEOUT SHALL win, with bus_err=0.
REQ-029 busy SHALL be 1 in REQ and RESP and 0 in IDLE.

Reset
REQ-030 rst=1 SHALL immediately force IDLE and set every output to 0, counter and latches to 0; this SHALL apply mid-transaction, dropping dbus_req asynchronously.
REQ-031 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-032 Macro LSU_MISALIGN_CHECK_EN defined: behaviour per REQ-016/017.
REQ-033 Macro LSU_MISALIGN_CHECK_EN undefined: misaligned SHALL be tied 0; addr SHALL be aligned down to the access size (half clears addr[0], word clears addr[1:0]) before lane selection, and the access SHALL proceed on the bus.

Structure
REQ-034 The shared defines file SHALL hold the encodings: MEM_OP NONE 00/LOAD 01/STORE 10; MEM_RD NONE 000/BYTE 001/HALF 010/WORD 011/B_U 100/H_U 101; MEM_WR masks per REQ-006; and the FSM state codes.
REQ-035 Load lane select/extension SHALL be a combinational sub-module, load_extend.

Verification
REQ-036 lb at addr 0x103, dbus_rdata 0x80FF_1234 with ack after 3 cycles -> done 1 cycle after ack, rdata_out 0xFFFF_FF80.
REQ-037 sh at addr 0x202, wdata 0x0000_ABCD -> dbus_addr 0x200, wstrb 1100, wdata 0xABCD_ABCD, we=1.
REQ-038 lw at addr 0x101 with macro defined -> no dbus_req, done next cycle, misaligned=1; with macro undefined -> dbus_addr 0x100, misaligned=0.
REQ-039 BUS_TIMEOUT=4, ack never arrives -> dbus_req high for 4 cycles, then done with bus_err=1 and rdata_out 0.
REQ-040 rst asserted mid-REQ -> dbus_req and busy 0 in the same cycle; a subsequent lhu at 0x0 with rdata 0x0000_8001 -> rdata_out 0x0000_8001.
